keyed_seq_fsm: RTL

Key-locked sequencing controller for the locked-FSM benchmark set. A correct key steers the machine through its functional run. A wrong key diverts it into a decoy path with identical timing and corrupted outputs, and repeated failures lock it permanently until reset. It generalises single-bit duplicate-state locking to a parametrised key width, run length and failure lockout.

---
 rtl/keyed_seq_fsm.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/keyed_seq_fsm.sv
// Key-locked sequencing controller: a correct key runs the counting sequence,
// a wrong key runs a bit-0-corrupted decoy and repeated failures lock to TRAP.
module keyed_seq_fsm #(
    parameter int               KEY_W    = 8,
    parameter logic [KEY_W-1:0] KEY      = 8'hA5,
    parameter int               OUT_W    = 8,
    parameter int               RUN_LEN  = 4,
    parameter int               MAX_FAIL = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [KEY_W-1:0]              keyinput,
    input  logic [OUT_W-1:0]              seed,
    output logic [OUT_W-1:0]              y,
    output logic                          busy,
    output logic                          done,
    output logic                          trapped,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int FC_W  = $clog2(MAX_FAIL + 1);
    localparam int CNT_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MAX_FAIL - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);
    localparam logic [OUT_W-1:0] LSB      = OUT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DECOY = 3'd2,
        S_DONE  = 3'd3,
        S_TRAP  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] w_acc_nxt;
    logic [OUT_W-1:0] w_acc_inc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [OUT_W-1:0] r_y;
    logic [OUT_W-1:0] w_y_nxt;
    logic [FC_W-1:0]  r_fail_cnt;
    logic [FC_W-1:0]  w_fc_nxt;
    logic             w_key_ok;

    assign w_key_ok  = (keyinput == KEY);
    assign w_acc_inc = r_acc + LSB;

    // State register; reset always lands in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: accumulator, run counter, output, failure count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_y        <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_y        <= w_y_nxt;
            r_fail_cnt <= w_fc_nxt;
        end
    end

    // Next-state and next-datapath decode; unknown encodings fall back to IDLE
    always_comb begin
        w_state_nxt = S_IDLE;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_y_nxt     = r_y;
        w_fc_nxt    = r_fail_cnt;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
                if (start) begin
                    w_acc_nxt = seed;
                    w_cnt_nxt = '0;
                    if (w_key_ok) begin
                        w_state_nxt = S_RUN;
                        w_y_nxt     = seed;
                    end else begin
                        w_state_nxt = S_DECOY;
                        w_y_nxt     = seed ^ LSB;
                    end
                end
            end
            S_RUN, S_DECOY: begin
                w_state_nxt = r_state;
                if (r_cnt != CNT_LAST) begin
                    w_acc_nxt = w_acc_inc;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_state == S_DECOY) begin
                        w_y_nxt = w_acc_inc ^ LSB;
                    end else begin
                        w_y_nxt = w_acc_inc;
                    end
                end else if (r_state == S_RUN) begin
                    w_state_nxt = S_DONE;
                    w_fc_nxt    = '0;
                end else if (r_fail_cnt >= FC_LAST) begin
                    w_state_nxt = S_TRAP;
                    w_fc_nxt    = FC_MAX;
                    w_y_nxt     = '0;
                end else begin
                    w_state_nxt = S_DONE;
                    w_fc_nxt    = r_fail_cnt + FC_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_TRAP: begin
                w_state_nxt = S_TRAP;
                w_y_nxt     = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign y        = r_y;
    assign busy     = (r_state == S_RUN) || (r_state == S_DECOY);
    assign done     = (r_state == S_DONE);
    assign trapped  = (r_state == S_TRAP);
    assign fail_cnt = r_fail_cnt;

endmodule
